video_sig_gen: RTL and testbench

Free-running 720p60 raster timing generator. Produces pixel coordinates, sync pulses and frame/line strobes for the video pipeline. Sits directly upstream of the video delay-compensation stage, which consumes h_count/v_count/active_draw. All outputs are registered and mutually aligned: every output describes the same pixel in the same cycle.

---
 rtl/video_timing_pkg.sv | 31 +++
 rtl/video_sig_gen_if.sv | 43 ++++
 rtl/video_sig_gen_wrap_counter.sv | 35 +++
 rtl/video_sig_gen.sv | 126 ++++++++++++
 tb/tb_video_sig_gen.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// 720p60 raster constants, count widths and FSM state type shared by the
// timing generator and the downstream delay-compensation stage.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned H_FP     = 110;
    localparam int unsigned H_SYNC   = 40;
    localparam int unsigned H_BP     = 220;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 720;
    localparam int unsigned V_FP     = 5;
    localparam int unsigned V_SYNC   = 5;
    localparam int unsigned V_BP     = 20;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned H_CNT_W     = 11;
    localparam int unsigned V_CNT_W     = 10;
    localparam int unsigned FRAME_CNT_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/video_sig_gen_if.sv
// Raster timing bundle from video_sig_gen to the video pipeline.
// frame_count_out exists only when VIDEO_SIG_GEN_FRAME_COUNT_EN is defined.
interface video_sig_gen_if;
    import video_timing_pkg::*;

    logic [H_CNT_W-1:0]     h_count_out;
    logic [V_CNT_W-1:0]     v_count_out;
    logic                   active_draw_out;
    logic                   hsync_out;
    logic                   vsync_out;
    logic                   new_line_out;
    logic                   new_frame_out;
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_out;
`endif

    modport master (
        output h_count_out,
        output v_count_out,
        output active_draw_out,
        output hsync_out,
        output vsync_out,
        output new_line_out,
        output new_frame_out
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        , output frame_count_out
`endif
    );

    modport slave (
        input h_count_out,
        input v_count_out,
        input active_draw_out,
        input hsync_out,
        input vsync_out,
        input new_line_out,
        input new_frame_out
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        , input frame_count_out
`endif
    );

endinterface

// File: rtl/video_sig_gen_wrap_counter.sv
// Equality-wrap counter with enable and synchronous clear; exposes the
// value it will load next so callers can register outputs aligned with it.
module wrap_counter #(
    parameter int unsigned           WIDTH = 11,
    parameter logic [WIDTH-1:0]      MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    always_comb begin
        wrap = en && !clear && (count == MAX);
        if (clear || wrap) begin
            next = '0;
        end else if (en) begin
            next = count + WIDTH'(1);
        end else begin
            next = count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator (720p60 by default).
// Optional frame index output: define VIDEO_SIG_GEN_FRAME_COUNT_EN.
module video_sig_gen #(
    parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = video_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = video_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = video_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = video_timing_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    video_sig_gen_if.master  vid
);
    import video_timing_pkg::*;

    localparam int unsigned HW = video_timing_pkg::H_CNT_W;
    localparam int unsigned VW = video_timing_pkg::V_CNT_W;

    localparam logic [HW-1:0] H_MAX    = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [HW-1:0] H_ACT_LIM = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LIM = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    fsm_state_t    state;
    logic          idle;
    logic          running;
    logic [HW-1:0] h_count;
    logic [HW-1:0] h_next;
    logic          h_wrap;
    logic [VW-1:0] v_count;
    logic [VW-1:0] v_next;
    logic          v_wrap;
    logic          active_draw;
    logic          hsync;
    logic          vsync;
    logic          new_line;
    logic          new_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= RUN;
        end
    end

    assign idle    = (state == IDLE);
    assign running = (state == RUN);

    wrap_counter #(
        .WIDTH (HW),
        .MAX   (H_MAX)
    ) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (idle),
        .en    (running),
        .count (h_count),
        .next  (h_next),
        .wrap  (h_wrap)
    );

    wrap_counter #(
        .WIDTH (VW),
        .MAX   (V_MAX)
    ) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (idle),
        .en    (h_wrap),
        .count (v_count),
        .next  (v_next),
        .wrap  (v_wrap)
    );

    // Decoded from the counters' next values so they land with the counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_draw <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            new_line    <= 1'b0;
            new_frame   <= 1'b0;
        end else begin
            active_draw <= (h_next < H_ACT_LIM) && (v_next < V_ACT_LIM);
            hsync       <= (h_next >= HS_START) && (h_next <= HS_END);
            vsync       <= (v_next >= VS_START) && (v_next <= VS_END);
            new_line    <= (h_next == '0);
            new_frame   <= (h_next == '0) && (v_next == '0);
        end
    end

    assign vid.h_count_out     = h_count;
    assign vid.v_count_out     = v_count;
    assign vid.active_draw_out = active_draw;
    assign vid.hsync_out       = hsync;
    assign vid.vsync_out       = vsync;
    assign vid.new_line_out    = new_line;
    assign vid.new_frame_out   = new_frame;

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] frame_count;

    // v_wrap only fires on a raster wrap in RUN, so the IDLE->RUN frame stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (v_wrap) begin
            frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

    assign vid.frame_count_out = frame_count;
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Checks video_sig_gen (full 720p and a reduced raster) against a model that
// derives each pixel from the cycle index since reset release.
module tb_video_sig_gen;
    import video_timing_pkg::*;

    localparam int unsigned SHA = 20, SHFP = 4, SHS = 3, SHBP = 5;
    localparam int unsigned SVA = 10, SVFP = 2, SVS = 2, SVBP = 3;
    localparam int unsigned SHT = SHA + SHFP + SHS + SHBP;
    localparam int unsigned SVT = SVA + SVFP + SVS + SVBP;
    localparam int unsigned SFR = SHT * SVT;
    localparam int unsigned FHT = 1650;
    localparam int unsigned FVT = 750;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        act;
        logic        hs;
        logic        vs;
        logic        nl;
        logic        nf;
        logic [5:0]  fc;
    } vid_t;

    localparam vid_t FIRST_PIX = '{h: 11'd0, v: 10'd0, act: 1'b1, hs: 1'b0, vs: 1'b0,
                                   nl: 1'b1, nf: 1'b1, fc: 6'd0};

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint k = -1;
    int     tests = 0;
    int     fails = 0;

    video_sig_gen_if if_full();
    video_sig_gen_if if_small();

    video_sig_gen u_full (
        .clk (clk),
        .rst (rst),
        .vid (if_full)
    );

    video_sig_gen #(
        .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
        .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vid (if_small)
    );

    always #5 clk = ~clk;

    // Pixel n after release sits at (n mod line, (n mod frame) div line).
    function automatic vid_t model(input longint kk,
                                   input longint ha, input longint hfp, input longint hs, input longint hbp,
                                   input longint va, input longint vfp, input longint vs, input longint vbp);
        vid_t   e;
        longint ht, vt, fr, pos, h, v;
        e = '0;
        if (kk < 0) return e;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        fr  = ht * vt;
        pos = kk % fr;
        h   = pos % ht;
        v   = pos / ht;
        e.h   = 11'(h);
        e.v   = 10'(v);
        e.act = (h < ha) && (v < va);
        e.hs  = (h >= ha + hfp) && (h < ha + hfp + hs);
        e.vs  = (v >= va + vfp) && (v < va + vfp + vs);
        e.nl  = (h == 0);
        e.nf  = (h == 0) && (v == 0);
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        e.fc  = 6'((kk / fr) % 64);
`endif
        return e;
    endfunction

    function automatic vid_t model_full(input longint kk);
        return model(kk, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP);
    endfunction

    function automatic vid_t model_small(input longint kk);
        return model(kk, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP);
    endfunction

    function automatic vid_t sample_full();
        vid_t s;
        s = '0;
        s.h = if_full.h_count_out;  s.v = if_full.v_count_out;
        s.act = if_full.active_draw_out;
        s.hs = if_full.hsync_out;   s.vs = if_full.vsync_out;
        s.nl = if_full.new_line_out; s.nf = if_full.new_frame_out;
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        s.fc = if_full.frame_count_out;
`endif
        return s;
    endfunction

    function automatic vid_t sample_small();
        vid_t s;
        s = '0;
        s.h = if_small.h_count_out;  s.v = if_small.v_count_out;
        s.act = if_small.active_draw_out;
        s.hs = if_small.hsync_out;   s.vs = if_small.vsync_out;
        s.nl = if_small.new_line_out; s.nf = if_small.new_frame_out;
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        s.fc = if_small.frame_count_out;
`endif
        return s;
    endfunction

    function automatic string fmt(input vid_t s);
        return $sformatf("h=%0d v=%0d act=%0b hs=%0b vs=%0b nl=%0b nf=%0b fc=%0d",
                         s.h, s.v, s.act, s.hs, s.vs, s.nl, s.nf, s.fc);
    endfunction

    // Drive rst for one edge, then sample 1 time unit after it.
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        k = r ? -1 : k + 1;
    endtask

    task automatic test_reset();
        vid_t g;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            g = sample_full();
            tests++;
            if (g !== vid_t'('0)) begin
                fails++;
                $display("FAIL reset_full cyc=%0d got %s req all zero", i, fmt(g));
            end
            g = sample_small();
            tests++;
            if (g !== vid_t'('0)) begin
                fails++;
                $display("FAIL reset_small cyc=%0d got %s req all zero", i, fmt(g));
            end
        end
        tick(1'b0);
        g = sample_full();
        tests++;
        if (g !== FIRST_PIX) begin
            fails++;
            $display("FAIL release_full got %s req %s", fmt(g), fmt(FIRST_PIX));
        end
        g = sample_small();
        tests++;
        if (g !== FIRST_PIX) begin
            fails++;
            $display("FAIL release_small got %s req %s", fmt(g), fmt(FIRST_PIX));
        end
    endtask

    task automatic test_line_timing();
        vid_t   g, e;
        logic   prev_act, prev_hs;
        int     act_falls, hs_rises, hs_run, nl_seen;
        longint last_nl;
        tick(1'b1);
        tick(1'b0);
        prev_act = 1'b0; prev_hs = 1'b0;
        act_falls = 0; hs_rises = 0; hs_run = 0; nl_seen = 0; last_nl = -1;
        for (int i = 0; i < int'(2 * FHT + 5); i++) begin
            g = sample_full();
            e = model_full(k);
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL line_cycle k=%0d got %s req %s", k, fmt(g), fmt(e));
            end
            if (prev_act && !g.act) begin
                act_falls++;
                tests++;
                if (g.h !== 11'd1280) begin
                    fails++;
                    $display("FAIL act_fall_h got %0d req 1280", g.h);
                end
            end
            if (!prev_hs && g.hs) begin
                hs_rises++;
                tests++;
                if (g.h !== 11'd1390) begin
                    fails++;
                    $display("FAIL hsync_rise_h got %0d req 1390", g.h);
                end
            end
            if (prev_hs && !g.hs) begin
                tests += 2;
                if (g.h !== 11'd1430) begin
                    fails++;
                    $display("FAIL hsync_fall_h got %0d req 1430", g.h);
                end
                if (hs_run != 40) begin
                    fails++;
                    $display("FAIL hsync_width got %0d req 40", hs_run);
                end
                hs_run = 0;
            end
            if (g.hs) hs_run++;
            if (g.nl) begin
                nl_seen++;
                if (last_nl >= 0) begin
                    tests++;
                    if (k - last_nl != longint'(FHT)) begin
                        fails++;
                        $display("FAIL new_line_period got %0d req %0d", k - last_nl, FHT);
                    end
                end
                last_nl = k;
            end
            prev_act = g.act;
            prev_hs  = g.hs;
            tick(1'b0);
        end
        tests += 3;
        if (act_falls != 2) begin
            fails++;
            $display("FAIL act_fall_count got %0d req 2", act_falls);
        end
        if (hs_rises != 2) begin
            fails++;
            $display("FAIL hsync_rise_count got %0d req 2", hs_rises);
        end
        if (nl_seen != 3) begin
            fails++;
            $display("FAIL new_line_count got %0d req 3", nl_seen);
        end
    endtask

    task automatic test_frame_timing();
        vid_t   g, e, pe;
        longint last_nf;
        int     act_cnt, vs_cnt, nf_seen, line_act;
        tick(1'b1);
        tick(1'b0);
        pe = '0;
        last_nf = -1; act_cnt = 0; vs_cnt = 0; nf_seen = 0; line_act = 0;
        for (int i = 0; i <= int'(2 * SFR); i++) begin
            g = sample_small();
            e = model_small(k);
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL frame_cycle k=%0d got %s req %s", k, fmt(g), fmt(e));
            end
            if (g.nf) begin
                nf_seen++;
                if (last_nf >= 0) begin
                    tests += 3;
                    if (k - last_nf != longint'(SFR)) begin
                        fails++;
                        $display("FAIL new_frame_period got %0d req %0d", k - last_nf, SFR);
                    end
                    if (act_cnt != int'(SHA * SVA)) begin
                        fails++;
                        $display("FAIL active_per_frame got %0d req %0d", act_cnt, SHA * SVA);
                    end
                    if (vs_cnt != int'(SVS * SHT)) begin
                        fails++;
                        $display("FAIL vsync_per_frame got %0d req %0d", vs_cnt, SVS * SHT);
                    end
                end
                last_nf = k; act_cnt = 0; vs_cnt = 0;
            end
            act_cnt += int'(g.act);
            vs_cnt  += int'(g.vs);
            if (i > 0 && pe.h == 11'(SHT - 1) && pe.v == 10'(SVT - 1)) begin
                tests++;
                if (g.h !== 11'd0 || g.v !== 10'd0 || g.nf !== 1'b1) begin
                    fails++;
                    $display("FAIL raster_wrap got %s req h=0 v=0 nf=1", fmt(g));
                end
            end
            if (i > 0 && pe.h == 11'(SHT - 1) && pe.v == 10'(SVA - 1)) begin
                tests++;
                if (g.v !== 10'(SVA) || g.act !== 1'b0) begin
                    fails++;
                    $display("FAIL last_active_wrap got %s req v=%0d act=0", fmt(g), SVA);
                end
            end
            if (e.v == 10'(SVA)) line_act += int'(g.act);
            if (e.v == 10'(SVA) && e.h == 11'(SHT - 1)) begin
                tests++;
                if (line_act != 0) begin
                    fails++;
                    $display("FAIL blank_line_active got %0d req 0", line_act);
                end
                line_act = 0;
            end
            pe = e;
            tick(1'b0);
        end
        tests++;
        if (nf_seen != 3) begin
            fails++;
            $display("FAIL new_frame_count got %0d req 3", nf_seen);
        end
    endtask

    task automatic test_mid_frame_reset();
        vid_t g, e;
        int   run_len, hold;
        tick(1'b1);
        tick(1'b0);
        while (k < longint'(400 * 0 + 2 * FHT + 700)) begin
            g = sample_full();
            e = model_full(k);
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL mid_run_full k=%0d got %s req %s", k, fmt(g), fmt(e));
            end
            tick(1'b0);
        end
        tick(1'b1);
        g = sample_full();
        tests++;
        if (g !== vid_t'('0)) begin
            fails++;
            $display("FAIL mid_reset_full got %s req all zero", fmt(g));
        end
        tick(1'b0);
        g = sample_full();
        tests++;
        if (g !== FIRST_PIX) begin
            fails++;
            $display("FAIL mid_release_full got %s req %s", fmt(g), fmt(FIRST_PIX));
        end
        for (int r = 0; r < 6; r++) begin
            run_len = int'($urandom_range(1, 1500));
            hold    = int'($urandom_range(1, 3));
            for (int i = 0; i < run_len; i++) begin
                tick(1'b0);
                g = sample_full();
                e = model_full(k);
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL rand_full k=%0d got %s req %s", k, fmt(g), fmt(e));
                end
                g = sample_small();
                e = model_small(k);
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL rand_small k=%0d got %s req %s", k, fmt(g), fmt(e));
                end
            end
            for (int i = 0; i < hold; i++) begin
                tick(1'b1);
                g = sample_small();
                tests++;
                if (g !== vid_t'('0)) begin
                    fails++;
                    $display("FAIL rand_reset_small got %s req all zero", fmt(g));
                end
            end
            tick(1'b0);
            g = sample_small();
            tests++;
            if (g !== FIRST_PIX) begin
                fails++;
                $display("FAIL rand_release_small got %s req %s", fmt(g), fmt(FIRST_PIX));
            end
        end
    endtask

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    task automatic test_frame_count();
        vid_t g, e;
        int   idx;
        tick(1'b1);
        tick(1'b0);
        idx = 0;
        for (int i = 0; i <= int'(65 * SFR); i++) begin
            g = sample_small();
            e = model_small(k);
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL fc_cycle k=%0d got %s req %s", k, fmt(g), fmt(e));
            end
            if (g.nf) begin
                tests++;
                if (g.fc !== 6'(idx % 64)) begin
                    fails++;
                    $display("FAIL frame_count pulse=%0d got %0d req %0d", idx, g.fc, idx % 64);
                end
                idx++;
            end
            tick(1'b0);
        end
        tests++;
        if (idx != 66) begin
            fails++;
            $display("FAIL frame_pulse_count got %0d req 66", idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_mid_frame_reset();
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
